dsm_adc_decim: RTL and testbench

Decimating receiver for the 1-bit delta-sigma bitstream produced by `dsm_dac`. It runs on the system `clk` and filters the bitstream with an order-N CIC decimator. It decimates by `OSR` and scales the result to the same 16-bit unsigned PCM format that `sin_gen` drives into `dsm_dac`. It closes the modulator loop in simulation (dac → decim round-trip checks) and serves as the front end of a future bitstream-input ADC path.

---
 rtl/dsm_pkg.sv | 33 +++
 rtl/cic_comb_stage.sv | 30 +++
 rtl/dsm_adc_decim.sv | 125 ++++++++++++
 tb/tb_dsm_adc_decim.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma DAC / decimator family.
//   pcm_t        : 16-bit unsigned offset-binary PCM sample
//   SCALE_K      : fractional bits of the decimator output scale factor
//   cic_width    : CIC register width N*clog2(R)+1 for decimation R, order N
//   cic_gain     : DC gain R^N of an order-N CIC decimating by R
//   scale_factor : floor((2^pcm_w-1) * 2^SCALE_K / R^N)
package dsm_pkg;

    localparam int unsigned SCALE_K = 32;

    typedef logic [15:0] pcm_t;

    function automatic int unsigned cic_width(input int unsigned r, input int unsigned n);
        return n * $clog2(r) + 1;
    endfunction

    function automatic logic [63:0] cic_gain(input int unsigned r, input int unsigned n);
        logic [63:0] g;
        g = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            g = g * 64'(r);
        end
        return g;
    endfunction

    function automatic logic [63:0] scale_factor(input int unsigned pcm_w, input int unsigned r,
                                                 input int unsigned n);
        logic [63:0] full;
        full = ((64'd1 << pcm_w) - 64'd1) << SCALE_K;
        return full / cic_gain(r, n);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y = x - x(previous decimated sample).
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   ce    : compute enable, high for one cycle per decimated sample
//   x     : stage input
//   y     : registered difference, updated only when ce is high
module cic_comb_stage #(
    parameter int unsigned W = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    logic [W-1:0] delay_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            delay_q <= '0;
            y       <= '0;
        end else if (ce) begin
            // Modulo-2^W subtraction; wrap-around is what makes the CIC work.
            delay_q <= x;
            y       <= x - delay_q;
        end
    end

endmodule

// File: rtl/dsm_adc_decim.sv
// Order-N CIC decimator for a 1-bit delta-sigma bitstream, scaled to
// unsigned PCM.
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   en        : sample enable; low freezes integrators and decimation counter
//   dsm_in    : 1-bit input bitstream
//   pcm_out   : decimated, scaled sample (unsigned offset-binary)
//   pcm_valid : one-cycle strobe marking a new pcm_out
module dsm_adc_decim
    import dsm_pkg::*;
#(
    parameter int unsigned OSR   = 100,
    parameter int unsigned ORDER = 2,
    parameter int unsigned PCM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dsm_in,
    output logic [PCM_W-1:0] pcm_out,
    output logic             pcm_valid
);

    localparam int unsigned W      = cic_width(OSR, ORDER);
    localparam int unsigned CNT_W  = $clog2(OSR);
    localparam int unsigned WARM_W = $clog2(ORDER + 1);
    localparam int unsigned PROD_W = W + 64;
    localparam logic [63:0] SCALE  = scale_factor(PCM_W, OSR, ORDER);
    localparam logic [PCM_W-1:0] PCM_MAX = '1;

    // The pipeline must drain before the next strobe can issue.
    if (OSR < ORDER + 3 || ORDER < 1 || ORDER > 3) begin : g_param_check
        $error("dsm_adc_decim: need 1 <= ORDER <= 3 and OSR >= ORDER+3");
    end

    logic [W-1:0]      integ_q [ORDER];
    logic [CNT_W-1:0]  cnt_q;
    logic [WARM_W-1:0] warm_q;
    logic [W-1:0]      cap_q;
    logic [ORDER:0]    tok_q;      // tok_q[k]: sample ready at comb stage k input
    logic              live_q;     // in-flight sample is past warm-up
    logic              scale_vld_q;
    logic [PCM_W-1:0]  pcm_s_q;
    logic [W-1:0]      comb_y [ORDER];
    logic              strobe;

    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] shifted;
    logic [PCM_W-1:0]  pcm_scaled;

    assign strobe = en && (cnt_q == CNT_W'(OSR - 1));

    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        logic [W-1:0] stage_x;
        if (g == 0) begin : g_first
            assign stage_x = cap_q;
        end else begin : g_next
            assign stage_x = comb_y[g-1];
        end
        cic_comb_stage #(
            .W(W)
        ) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .ce   (tok_q[g]),
            .x    (stage_x),
            .y    (comb_y[g])
        );
    end

    // Rounded fixed-point scale with saturation at full scale.
    always_comb begin
        prod       = PROD_W'(comb_y[ORDER-1]) * PROD_W'(SCALE) + (PROD_W'(1) << (SCALE_K - 1));
        shifted    = prod >> SCALE_K;
        pcm_scaled = (shifted > PROD_W'(PCM_MAX)) ? PCM_MAX : shifted[PCM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
            end
            cnt_q       <= '0;
            warm_q      <= '0;
            cap_q       <= '0;
            tok_q       <= '0;
            live_q      <= 1'b0;
            scale_vld_q <= 1'b0;
            pcm_s_q     <= '0;
            pcm_out     <= '0;
            pcm_valid   <= 1'b0;
        end else begin
            if (en) begin
                integ_q[0] <= integ_q[0] + W'(dsm_in);
                for (int unsigned k = 1; k < ORDER; k++) begin
                    integ_q[k] <= integ_q[k] + integ_q[k-1];
                end
                cnt_q <= strobe ? '0 : cnt_q + CNT_W'(1);
            end

            // Token shifts every clock regardless of en, so an issued sample
            // always completes on schedule.
            tok_q <= {tok_q[ORDER-1:0], strobe};

            if (strobe) begin
                cap_q  <= integ_q[ORDER-1];
                live_q <= (warm_q == WARM_W'(ORDER));
                if (warm_q != WARM_W'(ORDER)) begin
                    warm_q <= warm_q + WARM_W'(1);
                end
            end

            scale_vld_q <= tok_q[ORDER] && live_q;
            if (tok_q[ORDER]) begin
                pcm_s_q <= pcm_scaled;
            end

            pcm_valid <= scale_vld_q;
            if (scale_vld_q) begin
                pcm_out <= pcm_s_q;
            end
        end
    end

endmodule

// File: tb/tb_dsm_adc_decim.sv
module tb_dsm_adc_decim;

    localparam int R    = 100;
    localparam int N    = 2;
    localparam int LAT  = N + 2;
    localparam int HIST = 4096;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic        dsm_in = 1'b0;
    logic [15:0] pcm_out;
    logic        pcm_valid;

    always #5 clk = ~clk;

    dsm_adc_decim #(
        .OSR  (R),
        .ORDER(N),
        .PCM_W(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dsm_in   (dsm_in),
        .pcm_out  (pcm_out),
        .pcm_valid(pcm_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_range(input string name, input longint got, input longint lo, input longint hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t sb[$];
    bit   hist [HIST];
    int   cyc, en_idx, warm;
    int   first_valid, last_valid, n_valid, last_exp, last_dut;
    int   exp_first = 303;
    int   exp_space = 100;

    // Order-2 CIC as a triangular FIR over the enabled input bits.
    function automatic longint model_y(input int k);
        longint y;
        int     w, j;
        y = 0;
        for (int u = 1; u < 2 * R; u++) begin
            w = (u < 2 * R - u) ? u : 2 * R - u;
            j = k - 1 - u;
            if (j >= 0 && j < HIST && hist[j]) y += w;
        end
        return y;
    endfunction

    function automatic int exp_pcm(input longint y);
        longint unsigned scale, p;
        scale = (64'd65535 << 32) / 64'(R * R);
        p = (64'(y) * scale + (64'd1 << 31)) >> 32;
        if (p > 64'd65535) p = 64'd65535;
        return int'(p);
    endfunction

    logic r_s, e_s, b_s;
    int   cur;
    exp_t e_item;

    always @(posedge clk) begin
        r_s = rst_n;
        e_s = en;
        b_s = dsm_in;
        #1;
        if (!r_s) begin
            sb.delete();
            cyc = 0; en_idx = 0; warm = 0;
            first_valid = -1; last_valid = -1; n_valid = 0;
            chk("reset_valid", pcm_valid, 0);
            chk("reset_pcm", pcm_out, 0);
        end else begin
            cur = cyc;
            cyc++;
            if (e_s) begin
                if (en_idx < HIST) hist[en_idx] = b_s;
                if (en_idx % R == R - 1) begin
                    if (warm == N) begin
                        e_item.due = cur + LAT;
                        e_item.val = exp_pcm(model_y(en_idx));
                        sb.push_back(e_item);
                    end else begin
                        warm++;
                    end
                end
                en_idx++;
            end

            if (sb.size() > 0 && sb[0].due == cur) begin
                e_item = sb.pop_front();
                chk("valid_on_time", pcm_valid, 1);
                if (pcm_valid) begin
                    chk("pcm_value", pcm_out, e_item.val);
                    n_valid++;
                    if (first_valid < 0) begin
                        first_valid = cur;
                        chk("first_valid_cycle", cur, exp_first);
                    end else begin
                        chk("valid_spacing", cur - last_valid, exp_space);
                    end
                    last_valid = cur;
                    last_exp   = e_item.val;
                    last_dut   = int'(pcm_out);
                end
            end else if (pcm_valid) begin
                chk("spurious_valid", pcm_valid, 0);
            end else if (last_valid >= 0 && cur == last_valid + 50) begin
                chk("pcm_hold", pcm_out, last_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    int          pat, en_mode, stim_i;
    logic [15:0] acc;

    // Called at a negedge: sets inputs for the next posedge, then waits.
    task automatic drive(input int n);
        logic        e, b, c;
        logic [15:0] nxt;
        for (int i = 0; i < n; i++) begin
            e = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? (stim_i % 2 == 0) : 1'b0;
            case (pat)
                0: b = 1'b0;
                1: b = 1'b1;
                2: b = (stim_i % 2 == 0);
                default: begin
                    {c, nxt} = 17'(acc) + 17'h4000;
                    b = c;
                    if (e) acc = nxt;
                end
            endcase
            en     = e;
            dsm_in = b;
            stim_i++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        en     = 1'b0;
        dsm_in = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        stim_i = 0;
        acc    = '0;
    endtask

    typedef struct {
        int pat;
        int en_mode;
        int n_cycles;
        int first;
        int space;
        int count;
        int val;
        int tol;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{1, 0, 1000, 303, 100, 7, 65535, 0};    // all ones
        tbl[1] = '{0, 0, 1000, 303, 100, 7, 0,     0};    // all zeros
        tbl[2] = '{2, 0, 1000, 303, 100, 7, 32767, 0};    // alternating
        tbl[3] = '{3, 0, 1000, 303, 100, 7, 16384, 700};  // first-order DSM of 16'h4000
        tbl[4] = '{1, 1, 2000, 602, 200, 7, 65535, 0};    // en toggling 1 on / 1 off

        @(negedge clk);
        for (int t = 0; t < 5; t++) begin
            pat       = tbl[t].pat;
            en_mode   = tbl[t].en_mode;
            exp_first = tbl[t].first;
            exp_space = tbl[t].space;
            do_reset();
            drive(tbl[t].n_cycles);
            chk("valid_count", n_valid, tbl[t].count);
            chk_range("steady_value", last_dut, tbl[t].val - tbl[t].tol, tbl[t].val + tbl[t].tol);
        end

        // Reset two cycles after the strobe at cycle 399: that sample is dropped.
        pat = 1; en_mode = 0; exp_first = 303; exp_space = 100;
        do_reset();
        drive(401);
        chk("pre_reset_valids", n_valid, 1);
        do_reset();
        drive(420);
        chk("post_reset_valids", n_valid, 2);
        chk("post_reset_value", last_dut, 65535);

        // en low across the would-be strobe delays every strobe by 5 cycles.
        pat = 1; exp_first = 308; exp_space = 100;
        do_reset();
        en_mode = 0; drive(99);
        en_mode = 2; drive(5);
        en_mode = 0; drive(400);
        chk("en_gap_valids", n_valid, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout: simulation did not complete, got %0d checks", checks);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
